// File: rtl/fma_share_arbiter.sv
// fma_share_arbiter: round-robin sharing of one combinational FMA
// between N requesters, with a credit-limited in-order response FIFO.
module fma_share_arbiter #(
   parameter int N     = 4,
   parameter int DEPTH = 4,
   parameter int IDW   = $clog2(N),
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req_valid,
   output logic [N-1:0]    req_ready,
   input  logic [32*N-1:0] req_a,
   input  logic [32*N-1:0] req_b,
   input  logic [32*N-1:0] req_c,
   output logic [31:0]     fma_a,
   output logic [31:0]     fma_b,
   output logic [31:0]     fma_c,
   input  logic [31:0]     fma_out,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [31:0]     rsp_data,
   output logic [IDW-1:0]  rsp_id,
   output logic [CW-1:0]   in_flight
);

   localparam int PW = $clog2(DEPTH);

   logic [IDW-1:0] last_q;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic           accept;

   logic           s1_valid_q;
   logic [IDW-1:0] s1_id_q;
   logic [31:0]    fma_a_q, fma_b_q, fma_c_q;

   logic [31:0]    mem_d_q  [DEPTH];
   logic [IDW-1:0] mem_id_q [DEPTH];
   logic [PW-1:0]  wp_q, rp_q;
   logic [CW-1:0]  cnt_q;
   logic [CW-1:0]  in_flight_q, in_flight_d;
   logic           wr, pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Round-robin pick starting after last; credit uses the registered count
   always_comb begin
      int j;
      j      = 0;
      gnt    = '0;
      gnt_id = '0;
      accept = 1'b0;
      if (!rst && (in_flight_q < CW'(DEPTH))) begin
         for (int k = 1; k <= N; k++) begin
            j = int'(last_q) + k;
            if (j >= N) j = j - N;
            if (!accept && req_valid[j]) begin
               accept = 1'b1;
               gnt[j] = 1'b1;
               gnt_id = IDW'(j);
            end
         end
      end
   end

   assign req_ready = gnt;

   // S1: register granted operands onto the FMA and advance the pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q     <= IDW'(N - 1);
         s1_valid_q <= 1'b0;
         s1_id_q    <= '0;
         fma_a_q    <= '0;
         fma_b_q    <= '0;
         fma_c_q    <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            last_q  <= gnt_id;
            s1_id_q <= gnt_id;
            fma_a_q <= req_a[32*int'(gnt_id) +: 32];
            fma_b_q <= req_b[32*int'(gnt_id) +: 32];
            fma_c_q <= req_c[32*int'(gnt_id) +: 32];
         end
      end
   end

   assign fma_a = fma_a_q;
   assign fma_b = fma_b_q;
   assign fma_c = fma_c_q;

   assign wr  = s1_valid_q;
   assign pop = (cnt_q != '0) && rsp_ready;

   // S2 capture and response FIFO; reset clears storage so outputs read 0
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_d_q[i]  <= '0;
            mem_id_q[i] <= '0;
         end
      end else begin
         if (wr) begin
            mem_d_q[wp_q]  <= fma_out;
            mem_id_q[wp_q] <= s1_id_q;
            wp_q           <= ptr_inc(wp_q);
         end
         if (pop) rp_q <= ptr_inc(rp_q);
         if (wr && !pop) cnt_q <= cnt_q + CW'(1);
         else if (!wr && pop) cnt_q <= cnt_q - CW'(1);
      end
   end

   assign rsp_valid = (cnt_q != '0);
   assign rsp_data  = mem_d_q[rp_q];
   assign rsp_id    = mem_id_q[rp_q];

   always_comb begin
      in_flight_d = in_flight_q;
      if (accept && !pop) in_flight_d = in_flight_q + CW'(1);
      else if (!accept && pop) in_flight_d = in_flight_q - CW'(1);
   end

   // Credit counter: accepted operations not yet popped
   always_ff @(posedge clk) begin
      if (rst) in_flight_q <= '0;
      else     in_flight_q <= in_flight_d;
   end

   assign in_flight = in_flight_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(wr && (cnt_q == CW'(DEPTH))));

endmodule

// File: tb/tb_fma_share_arbiter.sv
// tb_fma_share_arbiter: scoreboard bench with a reference arbiter model
// and a stub FMA; every cycle is predicted and compared.
module tb_fma_share_arbiter;

   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int IDW   = 2;
   localparam int CW    = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [32*N-1:0] req_a, req_b, req_c;
   logic [31:0]     fma_a, fma_b, fma_c, fma_out;
   logic            rsp_valid, rsp_ready;
   logic [31:0]     rsp_data;
   logic [IDW-1:0]  rsp_id;
   logic [CW-1:0]   in_flight;

   fma_share_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_c(req_c),
      .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
      .fma_out(fma_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id),
      .in_flight(in_flight)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   logic real_mode = 1'b1;

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] fma_ref(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] c);
      if (a == 32'h40000000 && b == 32'h40400000 && c == 32'h3F800000)
         return 32'h40E00000;
      return 32'h7FC00000;
   endfunction

   always_comb begin
      fma_out = real_mode ? fma_ref(fma_a, fma_b, fma_c)
                          : fma_a + fma_b + fma_c;
   end

   int seq [N] = '{default: 0};

   function automatic logic [31:0] op_a(input int i, input int s);
      if (real_mode) return 32'h40000000;
      return (32'(i) << 24) | (32'(s) << 8) | 32'h1;
   endfunction
   function automatic logic [31:0] op_b(input int i, input int s);
      if (real_mode) return 32'h40400000;
      return 32'h00100000 * 32'(i + 1) + 32'(s);
   endfunction
   function automatic logic [31:0] op_c(input int i, input int s);
      if (real_mode) return 32'h3F800000;
      return 32'(s * 7 + i);
   endfunction

   // requester operands change only after the edge that consumed them
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         req_a[32*i +: 32] = op_a(i, seq[i]);
         req_b[32*i +: 32] = op_b(i, seq[i]);
         req_c[32*i +: 32] = op_c(i, seq[i]);
      end
   end

   typedef struct {
      int          cyc;
      int          id;
      logic [31:0] d;
   } exp_t;

   exp_t q [$];
   int cyc = 0;
   int last_m = N - 1;
   int infl_m = 0;
   logic [31:0] fa_m = 0, fb_m = 0, fc_m = 0;
   int acc_cnt [N] = '{default: 0};

   // reference model, evaluated mid-cycle once inputs have settled
   always @(negedge clk) begin
      logic [N-1:0] eg;
      logic         erv, epop;
      int           j, g;
      exp_t         e;
      eg = '0;
      g  = -1;
      if (rst) begin
         chk("ready_in_rst", 32'(req_ready), 32'h0);
         q.delete();
         last_m = N - 1;
         infl_m = 0;
         fa_m = 0; fb_m = 0; fc_m = 0;
      end else begin
         chk("in_flight", 32'(in_flight), 32'(infl_m));
         chk("fma_a", fma_a, fa_m);
         chk("fma_b", fma_b, fb_m);
         chk("fma_c", fma_c, fc_m);
         erv = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
         chk("rsp_valid", 32'(rsp_valid), 32'(erv));
         epop = erv && rsp_ready;
         if (erv) begin
            chk("rsp_data", rsp_data, q[0].d);
            chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
         end
         if (epop) void'(q.pop_front());
         if (infl_m < DEPTH) begin
            for (int k = 1; k <= N; k++) begin
               j = (last_m + k) % N;
               if (g < 0 && req_valid[j]) g = j;
            end
         end
         if (g >= 0) eg[g] = 1'b1;
         chk("req_ready", 32'(req_ready), 32'(eg));
         if (g >= 0) begin
            e.cyc = cyc;
            e.id  = g;
            fa_m  = req_a[32*g +: 32];
            fb_m  = req_b[32*g +: 32];
            fc_m  = req_c[32*g +: 32];
            e.d   = real_mode ? fma_ref(fa_m, fb_m, fc_m)
                              : fa_m + fb_m + fc_m;
            q.push_back(e);
            last_m = g;
            seq[g]++;
            acc_cnt[g]++;
         end
         infl_m = infl_m + ((g >= 0) ? 1 : 0) - (epop ? 1 : 0);
      end
      cyc++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      int base;
      rst = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      tick(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_fma_a", fma_a, 32'h0);
      chk("rst_rsp_data", rsp_data, 32'h0);
      chk("rst_rsp_id", 32'(rsp_id), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_in_flight", 32'(in_flight), 32'h0);

      // single real FMA op from requester 2
      tick(1);
      rsp_ready = 1'b1;
      req_valid = 4'b0100;
      @(negedge clk);
      chk("t1_grant", 32'(req_ready), 32'h4);
      tick(1);
      req_valid = '0;
      @(negedge clk);
      chk("t1_fma_a", fma_a, 32'h40000000);
      tick(1);
      @(negedge clk);
      chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t1_rsp_id", 32'(rsp_id), 32'h2);
      chk("t1_rsp_data", rsp_data, 32'h40E00000);
      tick(4);
      real_mode = 1'b0;
      tick(2);

      // all requesters streaming, round-robin
      req_valid = 4'b1111;
      tick(20);
      req_valid = '0;
      tick(8);

      // backpressure with requester 1
      rsp_ready = 1'b0;
      req_valid = 4'b0010;
      tick(8);
      @(negedge clk);
      chk("bp_in_flight", 32'(in_flight), 32'h4);
      chk("bp_ready", 32'(req_ready), 32'h0);
      tick(1);
      rsp_ready = 1'b1;
      tick(1);
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("bp_in_flight_after", 32'(in_flight), 32'h3);
      chk("bp_regrant", 32'(req_ready), 32'h2);
      tick(1);
      req_valid = '0;
      rsp_ready = 1'b1;
      tick(10);

      // lone requester 3
      base = acc_cnt[3];
      req_valid = 4'b1000;
      tick(10);
      req_valid = '0;
      chk("lone_accepts", 32'(acc_cnt[3] - base), 32'd10);
      tick(6);

      // reset with three operations in flight
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      tick(3);
      req_valid = '0;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_in_flight", 32'(in_flight), 32'h0);
      chk("mrst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("mrst_fma_a", fma_a, 32'h0);
      chk("mrst_rsp_data", rsp_data, 32'h0);
      tick(1);
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("mrst_first_grant", 32'(req_ready), 32'h1);
      tick(10);
      req_valid = '0;
      tick(8);

      // pop at full credit: in_flight 4,3,4
      rsp_ready = 1'b0;
      req_valid = 4'b0001;
      tick(6);
      @(negedge clk);
      chk("full_in_flight", 32'(in_flight), 32'h4);
      tick(1);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("full_pop_in_flight", 32'(in_flight), 32'h4);
      chk("full_pop_nogrant", 32'(req_ready), 32'h0);
      tick(1);
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("full_next_in_flight", 32'(in_flight), 32'h3);
      chk("full_next_grant", 32'(req_ready), 32'h1);
      tick(1);
      @(negedge clk);
      chk("full_refill", 32'(in_flight), 32'h4);
      tick(1);
      req_valid = '0;
      rsp_ready = 1'b1;
      tick(12);
      chk("drained", 32'(q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
